// File: rtl/brick_level_loader.sv
// brick_level_loader: walks one level of a synchronous level ROM into brick memory and hands each non-empty brick to the draw unit (in: start/level/abort, rom_data, draw_done; out: rom_addr, wr_en/address/health, draw_req/x_out/y_out, busy/done)
module brick_level_loader #(
  parameter int LEVEL_W    = 2,
  parameter int GRID_COLS  = 16,
  parameter int GRID_ROWS  = 8,
  parameter int ADDR_W     = 10,
  parameter int HEALTH_W   = 2,
  parameter int BRICK_W    = 20,
  parameter int BRICK_H    = 8,
  parameter int X_ORIGIN   = 0,
  parameter int Y_ORIGIN   = 0,
  parameter int SKIP_EMPTY = 1
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic                      start,
  input  logic                      abort,
  input  logic [LEVEL_W-1:0]        level,
  output logic [LEVEL_W+ADDR_W-1:0] rom_addr,
  input  logic [HEALTH_W-1:0]       rom_data,
  output logic                      wr_en,
  output logic [ADDR_W-1:0]         address,
  output logic [HEALTH_W-1:0]       health,
  output logic                      draw_req,
  input  logic                      draw_done,
  output logic [9:0]                x_out,
  output logic [9:0]                y_out,
  output logic                      busy,
  output logic                      done
);
  localparam int BRICKS = GRID_COLS * GRID_ROWS;
  localparam int COL_W = GRID_COLS > 1 ? $clog2(GRID_COLS) : 1;
  localparam logic [2:0] IDLE = 3'd0, FETCH = 3'd1, LOAD = 3'd2, WRITE = 3'd3, DRAW = 3'd4, DONE = 3'd5;
  logic [2:0] state;
  logic [ADDR_W-1:0] idx;
  logic [COL_W-1:0] col;
  logic [LEVEL_W-1:0] level_q;
  logic [HEALTH_W-1:0] health_q;
  logic adv, last, wrap;
  assign rom_addr = {level_q, idx};
  assign address = idx;
  assign health = health_q;
  assign wr_en = state == WRITE;
  assign draw_req = state == DRAW;
  assign done = state == DONE;
  assign busy = state != IDLE;
  always_comb begin
    adv = (state == WRITE && SKIP_EMPTY != 0 && health_q == '0) || (state == DRAW && draw_done);
    last = idx == ADDR_W'(BRICKS - 1);
    wrap = col == COL_W'(GRID_COLS - 1);
  end
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
      idx <= '0;
      col <= '0;
      level_q <= '0;
      health_q <= '0;
      x_out <= '0;
      y_out <= '0;
    end else if (abort) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE: if (start) begin
          level_q <= level;
          idx <= '0;
          col <= '0;
          x_out <= 10'(X_ORIGIN);
          y_out <= 10'(Y_ORIGIN);
          state <= FETCH;
        end
        FETCH: state <= LOAD;
        LOAD: begin
          health_q <= rom_data;
          state <= WRITE;
        end
        WRITE, DRAW: state <= adv ? (last ? DONE : FETCH) : DRAW;
        default: state <= IDLE;
      endcase
      if (adv && !last) begin
        idx <= idx + 1'b1;
        col <= wrap ? '0 : col + 1'b1;
        x_out <= wrap ? 10'(X_ORIGIN) : x_out + 10'(BRICK_W);
        y_out <= wrap ? y_out + 10'(BRICK_H) : y_out;
      end
    end
  end
endmodule

// File: tb/tb_brick_level_loader.sv
// tb_brick_level_loader: transaction-level model of the level loader checked against the DUT every cycle
module tb_brick_level_loader;
  localparam int LW = 2, AW = 3, HW = 2, COLS = 4, ROWS = 2, BW = 20, BH = 8;
  typedef struct {int a; int h;} wr_t;
  typedef struct {int x; int y; int h;} dr_t;
  logic clk = 0, resetn = 0, start = 0, abort = 0, draw_done = 0;
  logic [LW-1:0] level = 0;
  logic [LW+AW-1:0] rom_addr, rom_addr0;
  logic [HW-1:0] rom_data = 0, rom_data0 = 0, health, health0;
  logic wr_en, draw_req, busy, done, wr_en0, draw_req0, busy0, done0;
  logic [AW-1:0] address, address0;
  logic [9:0] x_out, y_out, x0, y0;
  logic [HW-1:0] rom [32] = '{1,1,1,1,1,1,1,1, 3,0,1,0,2,0,0,1, 0,2,3,1,0,1,2,3, 1,2,3,1,2,3,1,2};
  int ncmp = 0, nbad = 0, pcnt = 0, t0 = 0, ecyc = 0, dly = 1, dcnt = 0, dlen = 0, dcyc = -1, ndone = 0;
  int n0 = 0, lx0 = -1, ly0 = -1;
  bit tie = 1, chk = 0, pdr = 0, pdr0 = 0;
  wr_t wq[$];
  dr_t dq[$], dlog[$], cur;

  brick_level_loader #(.LEVEL_W(LW), .GRID_COLS(COLS), .GRID_ROWS(ROWS), .ADDR_W(AW), .HEALTH_W(HW),
    .BRICK_W(BW), .BRICK_H(BH), .X_ORIGIN(0), .Y_ORIGIN(0), .SKIP_EMPTY(1)) dut (
    .clk(clk), .resetn(resetn), .start(start), .abort(abort), .level(level), .rom_addr(rom_addr),
    .rom_data(rom_data), .wr_en(wr_en), .address(address), .health(health), .draw_req(draw_req),
    .draw_done(draw_done), .x_out(x_out), .y_out(y_out), .busy(busy), .done(done));

  brick_level_loader #(.LEVEL_W(LW), .GRID_COLS(COLS), .GRID_ROWS(ROWS), .ADDR_W(AW), .HEALTH_W(HW),
    .BRICK_W(BW), .BRICK_H(BH), .X_ORIGIN(0), .Y_ORIGIN(0), .SKIP_EMPTY(0)) dut0 (
    .clk(clk), .resetn(resetn), .start(start), .abort(abort), .level(level), .rom_addr(rom_addr0),
    .rom_data(rom_data0), .wr_en(wr_en0), .address(address0), .health(health0), .draw_req(draw_req0),
    .draw_done(1'b1), .x_out(x0), .y_out(y0), .busy(busy0), .done(done0));

  always #5 clk = ~clk;
  always @(posedge clk) begin
    pcnt <= pcnt + 1;
    rom_data <= rom[rom_addr];
    rom_data0 <= rom[rom_addr0];
  end

  task automatic cmp(string nm, int act, int exp);
    ncmp++;
    if (act != exp) begin
      nbad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // draw unit: either always ready, or answers on the dly-th DRAW cycle
  always @(negedge clk) begin
    if (tie) draw_done = 1;
    else if (draw_req) begin
      dcnt = dcnt + 1;
      draw_done = dcnt == dly;
    end else begin
      dcnt = 0;
      draw_done = 0;
    end
  end

  always @(negedge clk) begin
    if (done) ndone++;
    if (draw_req0 && !pdr0) begin
      n0++;
      lx0 = int'(x0);
      ly0 = int'(y0);
    end
    pdr0 = draw_req0;
  end

  always @(negedge clk) if (chk) begin
    int n;
    n = pcnt - t0;
    cmp("exclusive", int'(wr_en) + int'(draw_req) + int'(done) <= 1 ? 1 : 0, 1);
    cmp("busy", int'(busy), (n >= 1 && n <= ecyc) ? 1 : 0);
    cmp("done", int'(done), n == ecyc ? 1 : 0);
    if (done) dcyc = n;
    if (wr_en) begin
      if (wq.size() == 0) cmp("wr_extra", 1, 0);
      else begin
        wr_t w;
        w = wq.pop_front();
        cmp("wr_addr", int'(address), w.a);
        cmp("wr_health", int'(health), w.h);
      end
    end
    if (draw_req && !pdr) begin
      if (dq.size() == 0) cmp("draw_extra", 1, 0);
      else cur = dq.pop_front();
      dlog.push_back('{int'(x_out), int'(y_out), int'(health)});
      dlen = 0;
    end
    if (draw_req) begin
      dlen++;
      cmp("draw_x", int'(x_out), cur.x);
      cmp("draw_y", int'(y_out), cur.y);
      cmp("draw_health", int'(health), cur.h);
    end
    if (!draw_req && pdr) cmp("draw_len", dlen, tie ? 1 : dly);
    pdr = draw_req;
  end

  // expected writes/draws and done cycle straight from the grid geometry
  task automatic plan(int lvl, int d, bit t);
    wq.delete();
    dq.delete();
    ecyc = 1;
    for (int i = 0; i < COLS * ROWS; i++) begin
      int h;
      h = int'(rom[lvl * 8 + i]);
      wq.push_back('{i, h});
      ecyc += 3;
      if (h != 0) begin
        dq.push_back('{(i % COLS) * BW, (i / COLS) * BH, h});
        ecyc += t ? 1 : d;
      end
    end
  endtask

  task automatic load(int lvl, int d, bit t, bit poke);
    int nd;
    plan(lvl, d, t);
    dly = d;
    tie = t;
    @(negedge clk);
    level = LW'(lvl);
    start = 1;
    t0 = pcnt;
    pdr = 0;
    dcyc = -1;
    dlog.delete();
    nd = ndone;
    chk = 1;
    @(negedge clk);
    start = 0;
    cmp("fetch0_rom_addr", int'(rom_addr), lvl * 8);
    for (int c = 1; c < ecyc + 4; c++) begin
      @(negedge clk);
      if (poke && c == 10) begin
        start = 1;
        level = 3;
      end else start = 0;
    end
    chk = 0;
    cmp("writes_left", wq.size(), 0);
    cmp("draws_left", dq.size(), 0);
    cmp("done_count", ndone - nd, 1);
  endtask

  task automatic idle_outputs(string nm);
    cmp({nm, "_busy"}, int'(busy), 0);
    cmp({nm, "_wr_en"}, int'(wr_en), 0);
    cmp({nm, "_draw_req"}, int'(draw_req), 0);
    cmp({nm, "_done"}, int'(done), 0);
  endtask

  initial begin
    int nd;
    bit hit;
    #1;
    idle_outputs("reset");
    cmp("reset_rom_addr", int'(rom_addr), 0);
    cmp("reset_xy", int'(x_out) + int'(y_out), 0);
    repeat (2) @(negedge clk);
    resetn = 1;
    // level 1, draw unit always ready, plus the SKIP_EMPTY=0 twin
    n0 = 0;
    load(1, 1, 1, 0);
    cmp("t1_done_cycle", dcyc, 29);
    cmp("t1_draws", dlog.size(), 4);
    if (dlog.size() == 4) begin
      cmp("t1_d0", dlog[0].x * 1000 + dlog[0].y, 0);
      cmp("t1_d1", dlog[1].x * 1000 + dlog[1].y, 40000);
      cmp("t1_d2", dlog[2].x * 1000 + dlog[2].y, 8);
      cmp("t1_d3", dlog[3].x * 1000 + dlog[3].y, 60008);
    end
    cmp("noskip_draws", n0, 8);
    cmp("noskip_last_x", lx0, 60);
    cmp("noskip_last_y", ly0, 8);
    // slow draw unit, stray start/level change while busy
    load(1, 5, 0, 1);
    // async reset in the middle of drawing idx 3
    tie = 0;
    dly = 5;
    @(negedge clk);
    level = 3;
    start = 1;
    @(negedge clk);
    start = 0;
    hit = 0;
    for (int c = 0; c < 200 && !hit; c++) begin
      @(negedge clk);
      hit = draw_req && address == 3;
    end
    cmp("reach_draw3", int'(hit), 1);
    nd = ndone;
    resetn = 0;
    #1;
    idle_outputs("async_rst");
    cmp("async_rst_addr", int'(address), 0);
    cmp("async_rst_xy", int'(x_out) + int'(y_out), 0);
    repeat (2) @(negedge clk);
    resetn = 1;
    repeat (3) @(negedge clk);
    cmp("async_rst_no_done", ndone - nd, 0);
    load(2, 1, 1, 0);
    // abort in FETCH of idx 5
    @(negedge clk);
    level = 1;
    start = 1;
    @(negedge clk);
    start = 0;
    hit = 0;
    for (int c = 0; c < 200 && !hit; c++) begin
      @(negedge clk);
      hit = address == 5;
    end
    cmp("reach_fetch5", int'(hit), 1);
    cmp("fetch5_rom_addr", int'(rom_addr), 13);
    nd = ndone;
    abort = 1;
    @(negedge clk);
    abort = 0;
    idle_outputs("abort");
    repeat (4) @(negedge clk);
    cmp("abort_still_idle", int'(busy), 0);
    cmp("abort_no_done", ndone - nd, 0);
    // start and abort together in IDLE
    start = 1;
    abort = 1;
    @(negedge clk);
    start = 0;
    abort = 0;
    idle_outputs("start_abort");
    @(negedge clk);
    cmp("start_abort_idle", int'(busy), 0);
    load(3, 2, 0, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nbad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1);
  end
endmodule

// File: doc/brick_level_loader.md
Name: brick_level_loader

Overview:
- Parametrised successor of the single-level brick loader.
- On a start pulse, walks every brick slot of the selected level in an external synchronous level ROM.
- Writes each slot's health into brick memory and hands each non-empty brick to the drawing unit with a request/done handshake.
- Sits between the game FSM (start/level/done) and the brick memory plus VGA draw path; replaces the fixed per-brick delay counter with a real handshake.

Parameters:
- LEVEL_W, 2, level select width (2^LEVEL_W levels in ROM).
- GRID_COLS, 16, bricks per row.
- GRID_ROWS, 8, brick rows; BRICKS = GRID_COLS*GRID_ROWS, must be <= 2^ADDR_W.
- ADDR_W, 10, brick memory address width.
- HEALTH_W, 2, health field width (0 = empty slot).
- BRICK_W, 20, brick pitch in pixels, x.
- BRICK_H, 8, brick pitch in pixels, y.
- X_ORIGIN, 0, pixel x of brick 0.
- Y_ORIGIN, 0, pixel y of brick 0.
- SKIP_EMPTY, 1, 1: empty bricks are written but not drawn; 0: every brick is drawn.

Ports:
- clk  in  1  system clock, rising edge.
- resetn  in  1  asynchronous, active-low reset.
- start  in  1  begin loading; sampled only in IDLE.
- abort  in  1  synchronous cancel; return to IDLE without done.
- level  in  LEVEL_W  level number; latched on accepted start.
- rom_addr  out  LEVEL_W+ADDR_W  {level_q, idx} to level ROM.
- rom_data  in  HEALTH_W  ROM health; valid one cycle after rom_addr.
- wr_en  out  1  brick memory write strobe.
- address  out  ADDR_W  brick memory address (= idx).
- health  out  HEALTH_W  brick memory write data.
- draw_req  out  1  request drawing of the brick at x_out/y_out.
- draw_done  in  1  draw unit finished; sampled only in DRAW.
- x_out  out  10  pixel x of current brick.
- y_out  out  10  pixel y of current brick.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when the last brick completes.

Behaviour:
- Reset (async, resetn=0): state=IDLE. idx, col, row, level_q, health_q = 0. All outputs 0. rom_addr = 0.
- Takes effect immediately, including mid-load; no done is issued for an interrupted load.
- States: IDLE, FETCH, LOAD, WRITE, DRAW, DONE.
- IDLE: start=1 -> latch level, clear idx/col/row -> FETCH. start is ignored in all other states.
- FETCH (1 cycle): rom_addr = {level_q, idx} (held stable in all states) -> LOAD.
- LOAD (1 cycle): health_q <= rom_data -> WRITE.
- WRITE (1 cycle): wr_en=1, address=idx, health=health_q. Zero health is still written, so stale bricks from the previous level are cleared.
  - If SKIP_EMPTY=1 and health_q=0: advance.
  - Otherwise -> DRAW.
- DRAW: draw_req=1, held until draw_done is sampled high, then advance.
  - If draw_done is already high on the first DRAW cycle, DRAW lasts exactly 1 cycle.
  - x_out/y_out and health stay stable throughout DRAW.
- Advance: if idx = BRICKS-1 -> DONE. Otherwise idx+1 -> FETCH.
  - col+1; on col = GRID_COLS-1, col=0 and row+1. No divider is used.
- DONE (1 cycle): done=1, busy=1 -> IDLE (busy=0 next cycle).
- Outputs x_out = X_ORIGIN + col*BRICK_W and y_out = Y_ORIGIN + row*BRICK_H.
  - Both registered, updated on the idx advance; truncated to 10 bits.
  - Constant-multiply via accumulated pitch registers, not a multiplier.
- Cycle cost per brick: 3 cycles (skipped empty), 4 cycles (draw_done immediate), 3+N cycles (draw_done after N DRAW cycles).
- abort=1 in any non-IDLE state -> IDLE next cycle, wr_en/draw_req/done deasserted. abort has priority over draw_done and over advance. In IDLE, abort has priority over start.
- draw_done outside DRAW: ignored.
- Level change while busy: no effect until the next accepted start.
- wr_en, draw_req and done are mutually exclusive by state and are never asserted together.

Test Plan:
- Config GRID_COLS=4, GRID_ROWS=2, BRICK_W=20, BRICK_H=8, ROM level 1 = {3,0,1,0,2,0,0,1}, draw_done tied high, start with level=1:
  - 8 wr_en pulses, addresses 0..7, healths in ROM order.
  - draw_req only for idx 0,2,4,7.
  - (x,y) for those draws = (0,0),(40,0),(0,8),(60,8).
  - done pulses exactly once at cycle 1+3*4+4*4.
- Same config, SKIP_EMPTY=0 -> 8 draw_req, last at (60,8).
- draw_done delayed 5 cycles per request -> draw_req held 5 cycles each; x_out/y_out/health stable throughout.
- Assert resetn=0 while in DRAW for idx 3 -> outputs 0 immediately, no done. After release, start with level=2 -> loads from rom_addr {2,0}.
- abort during FETCH of idx 5 -> IDLE next cycle, busy=0, no done.
- start pulses during busy are ignored.
- start and abort high together in IDLE -> stays IDLE.
